// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate arbiter: state and lane encodings,
// the lane controller INDICATOR codes, and a small integer helper.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_OPEN_ENTRY = 2'b01,
        ST_OPEN_EXIT  = 2'b10,
        ST_CLOSING    = 2'b11
    } state_e;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_e;

    // INDICATOR codes driven by CAR_Parking_System, kept here for integration
    localparam logic [2:0] IND_IDLE       = 3'b000;
    localparam logic [2:0] IND_WAIT_PASS  = 3'b001;
    localparam logic [2:0] IND_WRONG_PASS = 3'b010;
    localparam logic [2:0] IND_RIGHT_PASS = 3'b011;
    localparam logic [2:0] IND_STOP       = 3'b100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane/gate signal bundle between the lane controllers and the gate arbiter.
interface parking_gate_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic             entry_grant;
    logic             exit_grant;
    logic             gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic [1:0]       state_o;
    logic [7:0]       timeout_cnt;

    modport master (
        output entry_req, exit_req, car_passed,
        input  entry_grant, exit_grant, gate_open, occupancy, full, empty,
               state_o, timeout_cnt
    );

    modport slave (
        input  entry_req, exit_req, car_passed,
        output entry_grant, exit_grant, gate_open, occupancy, full, empty,
               state_o, timeout_cnt
    );
endinterface

// File: rtl/parking_phase_timer.sv
// Down-counting phase timer: loads a cycle count, decrements on request and
// flags expiry when it reaches zero. Holds at zero.
module parking_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: load wins over decrement, never underflow
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate arbiter for the entry and exit lanes, with occupancy
// tracking. Optional macro PARK_TIMEOUT_STATS_EN enables the timeout counter.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 8,
    parameter int OPEN_CYCLES  = 16,
    parameter int CLOSE_CYCLES = 4,
    parameter int CNT_W        = $clog2(CAPACITY + 1)
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    parking_gate_arbiter_if.slave   bus
);

    localparam int TMAX = max_int(OPEN_CYCLES, CLOSE_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]    OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0]    CLOSE_LOAD = TW'(CLOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    state_e           state_q, state_d;
    lane_e            last_q, last_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             entry_grant_q, exit_grant_q;
    logic             full_s, empty_s, entry_ok_s, exit_ok_s;
    logic             tmr_load_s, tmr_dec_s, tmr_expired_s;
    logic [TW-1:0]    tmr_val_s;

    assign full_s     = (occ_q == CAP_C);
    assign empty_s    = (occ_q == {CNT_W{1'b0}});
    assign entry_ok_s = bus.entry_req && !full_s;
    assign exit_ok_s  = bus.exit_req && !empty_s;

    parking_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk_i      (CLOCK),
        .rst_ni     (RESET),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .expired_o  (tmr_expired_s)
    );

    // next state, round-robin arbitration, occupancy and timer control
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        occ_d      = occ_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = {TW{1'b0}};
        tmr_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // a tie goes to the lane that was not served last
                if (entry_ok_s && (!exit_ok_s || (last_q == LANE_EXIT))) begin
                    state_d    = ST_OPEN_ENTRY;
                    last_d     = LANE_ENTRY;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = OPEN_LOAD;
                end else if (exit_ok_s) begin
                    state_d    = ST_OPEN_EXIT;
                    last_d     = LANE_EXIT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = OPEN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN_ENTRY, ST_OPEN_EXIT: begin
                if (bus.car_passed) begin
                    if (state_q == ST_OPEN_ENTRY) begin
                        if (occ_q != CAP_C) begin
                            occ_d = occ_q + ONE_C;
                        end else begin
                            occ_d = occ_q;
                        end
                    end else begin
                        if (occ_q != {CNT_W{1'b0}}) begin
                            occ_d = occ_q - ONE_C;
                        end else begin
                            occ_d = occ_q;
                        end
                    end
                    state_d    = ST_CLOSING;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CLOSE_LOAD;
                end else if (tmr_expired_s) begin
                    state_d    = ST_CLOSING;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CLOSE_LOAD;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_CLOSING: begin
                if (tmr_expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, arbitration history, occupancy and registered grants
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            last_q        <= LANE_EXIT;
            occ_q         <= {CNT_W{1'b0}};
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            occ_q         <= occ_d;
            entry_grant_q <= (state_d == ST_OPEN_ENTRY);
            exit_grant_q  <= (state_d == ST_OPEN_EXIT);
        end
    end

`ifdef PARK_TIMEOUT_STATS_EN
    logic       timeout_s;
    logic [7:0] tmo_cnt_q;

    assign timeout_s = ((state_q == ST_OPEN_ENTRY) || (state_q == ST_OPEN_EXIT))
                       && !bus.car_passed && tmr_expired_s;

    // saturating count of grants that closed without a car
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            tmo_cnt_q <= 8'd0;
        end else if (timeout_s && (tmo_cnt_q != 8'hFF)) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_q <= tmo_cnt_q;
        end
    end

    assign bus.timeout_cnt = tmo_cnt_q;
`else
    assign bus.timeout_cnt = 8'd0;
`endif

    assign bus.entry_grant = entry_grant_q;
    assign bus.exit_grant  = exit_grant_q;
    assign bus.gate_open   = entry_grant_q | exit_grant_q;
    assign bus.occupancy   = occ_q;
    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter (CAPACITY=2, OPEN=4, CLOSE=2),
// directed scenarios plus a randomized run against a phase-level model.
module tb_parking_gate_arbiter;

    localparam int CAP   = 2;
    localparam int OPENC = 4;
    localparam int CLOSC = 2;
    localparam int CW    = $clog2(CAP + 1);

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // model: phase 0 idle, 1 open entry, 2 open exit, 3 closing
    int m_phase, m_occ, m_last, m_left, m_to;

    parking_gate_arbiter_if #(.CNT_W(CW)) bus ();

    parking_gate_arbiter #(
        .CAPACITY     (CAP),
        .OPEN_CYCLES  (OPENC),
        .CLOSE_CYCLES (CLOSC),
        .CNT_W        (CW)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic model_reset();
        m_phase = 0; m_occ = 0; m_last = 1; m_left = 0; m_to = 0;
    endtask

    task automatic model_step(input bit er, input bit xr, input bit cp);
        bit eok, xok;
        eok = er && (m_occ < CAP);
        xok = xr && (m_occ > 0);
        case (m_phase)
            0: begin
                if (eok && (!xok || m_last == 1)) begin
                    m_phase = 1; m_last = 0; m_left = OPENC;
                end else if (xok) begin
                    m_phase = 2; m_last = 1; m_left = OPENC;
                end
            end
            1, 2: begin
                if (cp) begin
                    if (m_phase == 1 && m_occ < CAP) m_occ++;
                    if (m_phase == 2 && m_occ > 0) m_occ--;
                    m_phase = 3; m_left = CLOSC;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 3; m_left = CLOSC;
`ifdef PARK_TIMEOUT_STATS_EN
                        if (m_to < 255) m_to++;
`endif
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    // one clock: drive at negedge, model follows the edge, return at negedge
    task automatic cycle(input bit er, input bit xr, input bit cp);
        bus.entry_req  = er;
        bus.exit_req   = xr;
        bus.car_passed = cp;
        @(posedge CLOCK);
        model_step(er, xr, cp);
        @(negedge CLOCK);
    endtask

    task automatic do_reset();
        bus.entry_req = 1'b0; bus.exit_req = 1'b0; bus.car_passed = 1'b0;
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        model_reset();
    endtask

    // request until granted, pulse car on grant cycle car_at (0 = never), run to IDLE
    task automatic run_grant(input bit er, input bit xr, input int car_at,
                             output int g_e, output int g_x, output int close_n,
                             output bit to);
        bit req_e, req_x, cp;
        req_e = er; req_x = xr;
        g_e = 0; g_x = 0; close_n = 0; to = 1'b1;
        for (int n = 0; n < 60; n++) begin
            cp = bus.gate_open && ((g_e + g_x) == car_at);
            cycle(req_e, req_x, cp);
            if (bus.entry_grant) begin g_e++; req_e = 1'b0; end
            if (bus.exit_grant) begin g_x++; req_x = 1'b0; end
            if (bus.state_o == 2'b11) close_n++;
            if (bus.state_o == 2'b00 && (g_e + g_x + close_n) > 0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus.state_o, bus.entry_grant, bus.exit_grant, bus.gate_open,
             bus.full, bus.empty} !== 7'b0000001 || bus.occupancy !== CW'(0)
            || bus.timeout_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset: state=%b eg=%b xg=%b go=%b full=%b empty=%b occ=%0d to=%0d, want 00 0 0 0 0 1 0 0",
                     bus.state_o, bus.entry_grant, bus.exit_grant, bus.gate_open,
                     bus.full, bus.empty, bus.occupancy, bus.timeout_cnt);
        end
    endtask

    task automatic test_entry_car();
        int ge, gx, cn; bit to;
        run_grant(1'b1, 1'b0, 2, ge, gx, cn, to);
        tests_run++;
        if (to !== 1'b0 || ge != 2 || gx != 0 || cn != 2 || bus.occupancy !== CW'(1)
            || bus.state_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL entry_car: to=%b eg_cycles=%0d xg_cycles=%0d close=%0d occ=%0d state=%b, want 0 2 0 2 1 00",
                     to, ge, gx, cn, bus.occupancy, bus.state_o);
        end
    endtask

    task automatic test_full();
        int ge, gx, cn, bad; bit to;
        run_grant(1'b1, 1'b0, 1, ge, gx, cn, to);
        tests_run++;
        if (to !== 1'b0 || ge != 1 || bus.occupancy !== CW'(2) || bus.full !== 1'b1
            || bus.empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill: to=%b eg_cycles=%0d occ=%0d full=%b empty=%b, want 0 1 2 1 0",
                     to, ge, bus.occupancy, bus.full, bus.empty);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (bus.entry_grant || bus.state_o != 2'b00) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL full_block: %0d cycles with grant or non-idle, want 0", bad);
        end
    endtask

    task automatic test_round_robin();
        int ge, gx, cn; bit to;
        run_grant(1'b0, 1'b1, 1, ge, gx, cn, to);
        tests_run++;
        if (to !== 1'b0 || gx != 1 || bus.occupancy !== CW'(1)) begin
            tests_failed++;
            $display("FAIL exit_car: to=%b xg_cycles=%0d occ=%0d, want 0 1 1", to, gx, bus.occupancy);
        end
        run_grant(1'b1, 1'b1, 0, ge, gx, cn, to);
        tests_run++;
        if (to !== 1'b0 || ge != 4 || gx != 0 || bus.occupancy !== CW'(1)) begin
            tests_failed++;
            $display("FAIL tie1: to=%b eg_cycles=%0d xg_cycles=%0d occ=%0d, want 0 4 0 1",
                     to, ge, gx, bus.occupancy);
        end
        run_grant(1'b1, 1'b1, 1, ge, gx, cn, to);
        tests_run++;
        if (to !== 1'b0 || ge != 0 || gx != 1 || bus.occupancy !== CW'(0)) begin
            tests_failed++;
            $display("FAIL tie2: to=%b eg_cycles=%0d xg_cycles=%0d occ=%0d, want 0 0 1 0",
                     to, ge, gx, bus.occupancy);
        end
    endtask

    task automatic test_timeout();
        int ge, gx, cn, bad; bit to;
        logic [7:0] want_to;
`ifdef PARK_TIMEOUT_STATS_EN
        want_to = 8'd1;
`else
        want_to = 8'd0;
`endif
        do_reset();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if (bus.gate_open || bus.state_o != 2'b00) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL empty_block: %0d cycles with grant or non-idle, want 0", bad);
        end
        run_grant(1'b1, 1'b0, 0, ge, gx, cn, to);
        tests_run++;
        if (to !== 1'b0 || ge != OPENC || cn != CLOSC || bus.occupancy !== CW'(0)
            || bus.timeout_cnt !== want_to) begin
            tests_failed++;
            $display("FAIL timeout: to=%b eg_cycles=%0d close=%0d occ=%0d tcnt=%0d, want 0 %0d %0d 0 %0d",
                     to, ge, cn, bus.occupancy, bus.timeout_cnt, OPENC, CLOSC, want_to);
        end
    endtask

    task automatic test_reset_mid_exit();
        int ge, gx, cn; bit to;
        run_grant(1'b1, 1'b0, 1, ge, gx, cn, to);
        cycle(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (bus.exit_grant !== 1'b1 || bus.state_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL open_exit: xg=%b state=%b, want 1 10", bus.exit_grant, bus.state_o);
        end
        #2 RESET = 1'b0;
        #1;
        tests_run++;
        if (bus.entry_grant !== 1'b0 || bus.exit_grant !== 1'b0 || bus.gate_open !== 1'b0
            || bus.state_o !== 2'b00 || bus.occupancy !== CW'(0) || bus.empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: eg=%b xg=%b go=%b state=%b occ=%0d empty=%b, want 0 0 0 00 0 1",
                     bus.entry_grant, bus.exit_grant, bus.gate_open, bus.state_o,
                     bus.occupancy, bus.empty);
        end
        bus.exit_req = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_stray_car();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (bus.occupancy !== CW'(0) || bus.state_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL car_idle: occ=%0d state=%b, want 0 00", bus.occupancy, bus.state_o);
        end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (bus.occupancy !== CW'(1) || bus.state_o !== 2'b11) begin
            tests_failed++;
            $display("FAIL car_closing: occ=%0d state=%b, want 1 11", bus.occupancy, bus.state_o);
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] act, exp;
        bit er, xr, cp;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            er = ($urandom_range(0, 2) != 0);
            xr = ($urandom_range(0, 2) != 0);
            cp = ($urandom_range(0, 3) == 0);
            cycle(er, xr, cp);
            act = {bus.state_o, bus.entry_grant, bus.exit_grant, bus.gate_open,
                   bus.full, bus.empty, bus.occupancy[1:0], 7'd0} ^ {7'd0, 1'b0, bus.timeout_cnt};
            exp = {2'(m_phase), m_phase == 1, m_phase == 2, (m_phase == 1) || (m_phase == 2),
                   m_occ == CAP, m_occ == 0, 2'(m_occ), 7'd0} ^ {7'd0, 1'b0, 8'(m_to)};
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got %h want %h (er=%b xr=%b cp=%b)",
                         n, act, exp, er, xr, cp);
            end
        end
    endtask

    initial begin
        model_reset();
        bus.entry_req = 1'b0; bus.exit_req = 1'b0; bus.car_passed = 1'b0;
        test_reset();
        test_entry_car();
        test_full();
        test_round_robin();
        test_timeout();
        test_reset_mid_exit();
        test_stray_car();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
